hmsg_rr_merge: RTL and testbench
================================

# hmsg_rr_merge

Two-input, one-output message merge for the hlang NS channel fabric. The block owns one outgoing channel and shares it between two incoming channels, `rcv0` and `rcv1`, using round-robin arbitration. A granted message is copied into an output register and acknowledged upstream at once (store-and-forward, one-entry buffer), then held on `snd0` until the downstream side acknowledges it. It sits between producers such as sources or cell outputs and a single consumer link, and raises `gch_ready` once it has initialised, like every other NS node.

## Interface
- `ASZ`, default `NS_ADDRESS_SIZE`: width of the src and dst fields.
- `DSZ`, default `NS_DATA_SIZE`: width of the dat field.
- `RSZ`, default `NS_REDUN_SIZE`: width of the red field.
- `gch_clk`  in  1  single clock; all state changes on the rising edge.
- `gch_reset`  in  1  asynchronous, active-low reset.
- `gch_ready`  out  1  node initialised.
- `rcvN_src`, `rcvN_dst`  in  ASZ  message addresses, N = 0, 1.
- `rcvN_dat`  in  DSZ  message data.
- `rcvN_red`  in  RSZ  redundancy field, passed through unchecked.
- `rcvN_req_in`  in  1  request toggle from the producer.
- `rcvN_ack_out`  out  1  acknowledge toggle back to the producer.
- `snd0_src`, `snd0_dst`  out  ASZ  forwarded addresses.
- `snd0_dat`  out  DSZ  forwarded data.
- `snd0_red`  out  RSZ  forwarded redundancy field.
- `snd0_req_out`  out  1  request toggle to the consumer.
- `snd0_ack_in`  in  1  acknowledge toggle from the consumer.

## Operation
- **Handshake (two-phase toggle).**
  - A message is pending on `rcvN` when `rcvN_req_in != rcvN_ack_out`.
  - The consumer has taken the `snd0` message when `snd0_ack_in == snd0_req_out`.
  - Message fields must be stable while pending.
- **Registers:** `rg_rdy`, `rg_ack0`, `rg_ack1`, `rgo_req`, the output message register, `rg_state` (IDLE/SEND) and `rg_pri` (0 or 1; the input that wins a tie).
- **Not ready** (`rg_rdy = 0`): the first edge after reset release sets `rg_rdy = 1`. No arbitration happens in that cycle.
- **IDLE** (`rg_rdy = 1`):
  - Nothing pending: remain in IDLE.
  - Only one input pending: grant it.
  - Both pending: grant `rg_pri`.
  - On grant, at the same edge: copy the granted message into the output register, toggle `rgo_req`, toggle that input's ack register, set `rg_pri` to the other input, and go to SEND.
- **SEND:**
  - Inputs are not sampled, so they hold or accumulate pending messages.
  - When `snd0_ack_in == rgo_req`, go to IDLE at the next edge.
- **Fairness:** `rg_pri` changes only on a grant. Under continuous two-input load, grants strictly alternate.
- **Input with no ack:** `rcvN_req_in` toggling again before its ack is not detectable and is a producer protocol violation; no check is made.
- **Reset (asynchronous, any time including mid-SEND):**
  - All registers return to 0 and `rg_state` to IDLE.
  - Any buffered message is discarded.
  - All outputs read 0 immediately: `gch_ready = 0`, `rcvN_ack_out = 0`, `snd0_req_out = 0`, all `snd0` fields 0.

## Timing
- Input pending before edge k (IDLE, ready): `snd0_req_out` and `rcvN_ack_out` toggle at edge k. Latency is 1 edge.
- `snd0_ack_in` matching before edge m (SEND): state is IDLE after edge m. The next grant is no earlier than edge m+1.
- Peak throughput is 1 message per 2 cycles when the consumer acks in the cycle after the request.
- Outputs are driven only from registers; there is no combinational path from inputs to outputs.
- Reset release: `gch_ready` rises at the first edge after `gch_reset` goes high. The earliest grant is the edge after that.

## Test plan
- **Reset/ready.**
  - Stimulus: hold `gch_reset` = 0 for 3 cycles, then release.
  - Required: all outputs 0 during reset; `gch_ready` = 1 one edge after release; no req toggle while `gch_ready` = 0.
- **Single input.**
  - Stimulus: `rcv1` sends dat = 0x5A, src = 3, dst = 7; consumer acks 2 cycles later.
  - Required: one edge after the request, `snd0` carries 0x5A/3/7, `snd0_req_out` = 1 and `rcv1_ack_out` = 1.
  - Required: `snd0_req_out` stays at 1 until the ack.
- **Simultaneous requests.**
  - Stimulus: `rcv0` (dat = 0x11) and `rcv1` (dat = 0x22) both pending after reset (`rg_pri` = 0); consumer acks immediately.
  - Required: output order is 0x11 then 0x22, two cycles apart; `rcv1_ack_out` toggles only on the second grant.
- **Continuous load.**
  - Stimulus: both producers re-request immediately for 8 messages each.
  - Required: grants strictly alternate 0, 1, 0, 1, …; all 16 messages are delivered in per-input order.
- **Backpressure.**
  - Stimulus: consumer withholds ack for 10 cycles.
  - Required: `snd0` fields and `snd0_req_out` stay constant for all 10 cycles; no input is acked during that time.
- **Reset mid-SEND.**
  - Stimulus: assert reset while a message is outstanding.
  - Required: outputs clear asynchronously before the next edge; after release the dropped message is not re-emitted.

Source files
------------

// File: rtl/hmsg_rr_merge.sv
// Two-input round-robin merge onto one NS output channel with a one-entry
// store-and-forward buffer and two-phase toggle handshakes on every link.

package hmsg_pkg;
  parameter int NS_ADDRESS_SIZE = 8;
  parameter int NS_DATA_SIZE    = 32;
  parameter int NS_REDUN_SIZE   = 8;
endpackage

module hmsg_rr_merge
  import hmsg_pkg::*;
#(
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE,
  parameter int RSZ = NS_REDUN_SIZE
) (
  input  logic           gch_clk,
  input  logic           gch_reset,
  output logic           gch_ready,
  input  logic [ASZ-1:0] rcv0_src,
  input  logic [ASZ-1:0] rcv0_dst,
  input  logic [DSZ-1:0] rcv0_dat,
  input  logic [RSZ-1:0] rcv0_red,
  input  logic           rcv0_req_in,
  output logic           rcv0_ack_out,
  input  logic [ASZ-1:0] rcv1_src,
  input  logic [ASZ-1:0] rcv1_dst,
  input  logic [DSZ-1:0] rcv1_dat,
  input  logic [RSZ-1:0] rcv1_red,
  input  logic           rcv1_req_in,
  output logic           rcv1_ack_out,
  output logic [ASZ-1:0] snd0_src,
  output logic [ASZ-1:0] snd0_dst,
  output logic [DSZ-1:0] snd0_dat,
  output logic [RSZ-1:0] snd0_red,
  output logic           snd0_req_out,
  input  logic           snd0_ack_in
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           rdy_q,   rdy_d;
  logic           ack0_q,  ack0_d;
  logic           ack1_q,  ack1_d;
  logic           req_q,   req_d;
  logic           pri_q,   pri_d;
  logic [ASZ-1:0] src_q,   src_d;
  logic [ASZ-1:0] dst_q,   dst_d;
  logic [DSZ-1:0] dat_q,   dat_d;
  logic [RSZ-1:0] red_q,   red_d;

  logic           pend0_s;
  logic           pend1_s;
  logic           gnt1_s;

  // Request detection and round-robin winner select
  always_comb begin
    pend0_s = rcv0_req_in ^ ack0_q;
    pend1_s = rcv1_req_in ^ ack1_q;
    // Input 1 wins when it is alone, or when both pend and it holds priority
    gnt1_s  = pend1_s & (~pend0_s | pri_q);
  end

  // Next-state logic: ready bring-up, grant in IDLE, wait for consumer in SEND
  always_comb begin
    state_d = state_q;
    rdy_d   = rdy_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    req_d   = req_q;
    pri_d   = pri_q;
    src_d   = src_q;
    dst_d   = dst_q;
    dat_d   = dat_q;
    red_d   = red_q;

    if (!rdy_q) begin
      rdy_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend0_s | pend1_s) begin
            if (gnt1_s) begin
              src_d  = rcv1_src;
              dst_d  = rcv1_dst;
              dat_d  = rcv1_dat;
              red_d  = rcv1_red;
              ack1_d = ~ack1_q;
            end else begin
              src_d  = rcv0_src;
              dst_d  = rcv0_dst;
              dat_d  = rcv0_dat;
              red_d  = rcv0_red;
              ack0_d = ~ack0_q;
            end
            req_d   = ~req_q;
            pri_d   = ~gnt1_s;
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SEND: begin
          if (snd0_ack_in == req_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and message registers; reset discards any buffered message
  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      req_q   <= 1'b0;
      pri_q   <= 1'b0;
      src_q   <= {ASZ{1'b0}};
      dst_q   <= {ASZ{1'b0}};
      dat_q   <= {DSZ{1'b0}};
      red_q   <= {RSZ{1'b0}};
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      req_q   <= req_d;
      pri_q   <= pri_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      dat_q   <= dat_d;
      red_q   <= red_d;
    end
  end

  assign gch_ready    = rdy_q;
  assign rcv0_ack_out = ack0_q;
  assign rcv1_ack_out = ack1_q;
  assign snd0_req_out = req_q;
  assign snd0_src     = src_q;
  assign snd0_dst     = dst_q;
  assign snd0_dat     = dat_q;
  assign snd0_red     = red_q;

endmodule

// File: tb/tb_hmsg_rr_merge.sv
// Randomised and directed bench for hmsg_rr_merge against a queue-based
// transaction model of the round-robin merge.

module tb_hmsg_rr_merge;
  localparam int ASZ = 8;
  localparam int DSZ = 16;
  localparam int RSZ = 4;

  typedef struct packed {
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
  } msg_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           gch_ready;
  logic [ASZ-1:0] rcv0_src, rcv0_dst, rcv1_src, rcv1_dst, snd0_src, snd0_dst;
  logic [DSZ-1:0] rcv0_dat, rcv1_dat, snd0_dat;
  logic [RSZ-1:0] rcv0_red, rcv1_red, snd0_red;
  logic           rcv0_req_in, rcv1_req_in, rcv0_ack_out, rcv1_ack_out;
  logic           snd0_req_out, snd0_ack_in;

  hmsg_rr_merge #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
    .gch_clk(clk), .gch_reset(rst_n), .gch_ready(gch_ready),
    .rcv0_src(rcv0_src), .rcv0_dst(rcv0_dst), .rcv0_dat(rcv0_dat), .rcv0_red(rcv0_red),
    .rcv0_req_in(rcv0_req_in), .rcv0_ack_out(rcv0_ack_out),
    .rcv1_src(rcv1_src), .rcv1_dst(rcv1_dst), .rcv1_dat(rcv1_dat), .rcv1_red(rcv1_red),
    .rcv1_req_in(rcv1_req_in), .rcv1_ack_out(rcv1_ack_out),
    .snd0_src(snd0_src), .snd0_dst(snd0_dst), .snd0_dat(snd0_dat), .snd0_red(snd0_red),
    .snd0_req_out(snd0_req_out), .snd0_ack_in(snd0_ack_in)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Transaction model: one outstanding message, per-input FIFOs, turn token
  msg_t q0[$];
  msg_t q1[$];
  msg_t m_out = '0;
  logic m_rdy = 1'b0, m_busy = 1'b0, m_req = 1'b0, m_ack0 = 1'b0, m_ack1 = 1'b0;
  int   m_turn = 0;
  int   gnt_log[$];
  logic prev_a0 = 1'b0, prev_a1 = 1'b0;

  task automatic model_eval();
    bit p0, p1;
    int w;
    if (!rst_n) begin
      m_rdy = 1'b0; m_busy = 1'b0; m_req = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
      m_turn = 0; m_out = '0; q0.delete(); q1.delete();
      prev_a0 = 1'b0; prev_a1 = 1'b0;
    end else if (!m_rdy) begin
      m_rdy = 1'b1;
    end else if (m_busy) begin
      if (snd0_ack_in == m_req) m_busy = 1'b0;
    end else begin
      p0 = (rcv0_req_in != m_ack0);
      p1 = (rcv1_req_in != m_ack1);
      if (p0 || p1) begin
        w = (p0 && p1) ? m_turn : (p1 ? 1 : 0);
        if (w == 0) begin
          if (q0.size() > 0) m_out = q0.pop_front();
          m_ack0 = ~m_ack0;
        end else begin
          if (q1.size() > 0) m_out = q1.pop_front();
          m_ack1 = ~m_ack1;
        end
        m_req  = ~m_req;
        m_turn = 1 - w;
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic compare_outs();
    check("ready", gch_ready, m_rdy);
    check("snd_req", snd0_req_out, m_req);
    check("ack0", rcv0_ack_out, m_ack0);
    check("ack1", rcv1_ack_out, m_ack1);
    check("snd_src", snd0_src, m_out.src);
    check("snd_dst", snd0_dst, m_out.dst);
    check("snd_dat", snd0_dat, m_out.dat);
    check("snd_red", snd0_red, m_out.red);
    if (rcv0_ack_out !== prev_a0) gnt_log.push_back(0);
    if (rcv1_ack_out !== prev_a1) gnt_log.push_back(1);
    prev_a0 = rcv0_ack_out;
    prev_a1 = rcv1_ack_out;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    @(negedge clk);
    compare_outs();
  endtask

  task automatic send(input int n, input msg_t m);
    if (n == 0) begin
      rcv0_src = m.src; rcv0_dst = m.dst; rcv0_dat = m.dat; rcv0_red = m.red;
      rcv0_req_in = ~rcv0_req_in;
      q0.push_back(m);
    end else begin
      rcv1_src = m.src; rcv1_dst = m.dst; rcv1_dat = m.dat; rcv1_red = m.red;
      rcv1_req_in = ~rcv1_req_in;
      q1.push_back(m);
    end
  endtask

  function automatic msg_t rand_msg();
    msg_t m;
    m.src = ASZ'($urandom);
    m.dst = ASZ'($urandom);
    m.dat = DSZ'($urandom);
    m.red = RSZ'($urandom);
    return m;
  endfunction

  function automatic msg_t mk(input int s, input int d, input int dat);
    msg_t m;
    m.src = ASZ'(s);
    m.dst = ASZ'(d);
    m.dat = DSZ'(dat);
    m.red = RSZ'(dat);
    return m;
  endfunction

  task automatic drive_random(input int pp, input int pc);
    if (rcv0_req_in == m_ack0 && $urandom_range(99) < pp) send(0, rand_msg());
    if (rcv1_req_in == m_ack1 && $urandom_range(99) < pp) send(1, rand_msg());
    if (snd0_ack_in != m_req && $urandom_range(99) < pc) snd0_ack_in = m_req;
  endtask

  initial begin
    int c0, c1, guard;
    logic a0_hold, a1_hold;
    rst_n = 1'b0;
    rcv0_src = '0; rcv0_dst = '0; rcv0_dat = '0; rcv0_red = '0; rcv0_req_in = 1'b0;
    rcv1_src = '0; rcv1_dst = '0; rcv1_dat = '0; rcv1_red = '0; rcv1_req_in = 1'b0;
    snd0_ack_in = 1'b0;

    // Reset and ready bring-up
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_release", gch_ready, 1'b1);
    check("no_req_at_ready", snd0_req_out, 1'b0);

    // Single input on rcv1
    send(1, mk(3, 7, 'h5A));
    tick();
    check("single_dat", snd0_dat, 16'h005A);
    check("single_src", snd0_src, 8'd3);
    check("single_dst", snd0_dst, 8'd7);
    check("single_req", snd0_req_out, 1'b1);
    check("single_ack1", rcv1_ack_out, 1'b1);
    tick();
    check("single_req_hold", snd0_req_out, 1'b1);
    snd0_ack_in = 1'b1;
    tick();
    tick();

    // Simultaneous requests with priority on input 0
    send(0, mk(1, 2, 'h11));
    send(1, mk(4, 5, 'h22));
    tick();
    check("simul_first", snd0_dat, 16'h0011);
    check("simul_ack1_hold", rcv1_ack_out, 1'b1);
    snd0_ack_in = snd0_req_out;
    tick();
    check("simul_gap", snd0_dat, 16'h0011);
    tick();
    check("simul_second", snd0_dat, 16'h0022);
    check("simul_ack1_toggle", rcv1_ack_out, 1'b0);
    snd0_ack_in = m_req;
    tick();
    tick();

    // Continuous load, 8 messages per input
    gnt_log.delete();
    c0 = 0; c1 = 0; guard = 0;
    while (guard < 200 && !(c0 == 8 && c1 == 8 && !m_busy &&
           rcv0_req_in == m_ack0 && rcv1_req_in == m_ack1)) begin
      if (rcv0_req_in == m_ack0 && c0 < 8) begin send(0, rand_msg()); c0++; end
      if (rcv1_req_in == m_ack1 && c1 < 8) begin send(1, rand_msg()); c1++; end
      snd0_ack_in = m_req;
      tick();
      guard++;
    end
    check("cont_timeout", guard < 200, 1'b1);
    check("cont_grants", gnt_log.size(), 16);
    for (int i = 1; i < gnt_log.size(); i++)
      check("cont_alternate", gnt_log[i], 1 - gnt_log[i-1]);
    tick();

    // Backpressure: consumer withholds ack for 10 cycles
    send(0, mk(9, 10, 'hBEEF));
    tick();
    send(1, mk(11, 12, 'h1234));
    a0_hold = rcv0_ack_out;
    a1_hold = rcv1_ack_out;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_dat", snd0_dat, 16'hBEEF);
      check("bp_src", snd0_src, 8'd9);
      check("bp_req", snd0_req_out, m_req);
      check("bp_ack0", rcv0_ack_out, a0_hold);
      check("bp_ack1", rcv1_ack_out, a1_hold);
    end
    snd0_ack_in = m_req;
    tick();
    tick();
    check("bp_next", snd0_dat, 16'h1234);

    // Reset while a message is outstanding
    snd0_ack_in = m_req;
    tick();
    send(0, mk(13, 14, 'hDEAD));
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", snd0_req_out, 1'b0);
    check("arst_ready", gch_ready, 1'b0);
    check("arst_dat", snd0_dat, 16'h0000);
    check("arst_acks", {rcv0_ack_out, rcv1_ack_out}, 2'b00);
    rcv0_req_in = 1'b0; rcv1_req_in = 1'b0; snd0_ack_in = 1'b0;
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    check("no_reemit", snd0_req_out, 1'b0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      drive_random(40, 50);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      snd0_ack_in = m_req;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
